// File: rtl/irrigation_countdown.sv
// Down-counting BCD irrigation timer (MM:SS, 00:00..99:59) with preset load,
// run/pause control and a completion pulse for the valve controller.
module irrigation_countdown #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic [3:0] pre_mt,
   input  logic [3:0] pre_mu,
   input  logic [3:0] pre_st,
   input  logic [3:0] pre_su,
   output logic [3:0] dig_mt,
   output logic [3:0] dig_mu,
   output logic [3:0] dig_st,
   output logic [3:0] dig_su,
   output logic       running,
   output logic       done,
   output logic       load_err
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state, state_n;
   logic [PW-1:0] presc, presc_n;
   logic [3:0]    mt, mu, st, su;
   logic [3:0]    mt_n, mu_n, st_n, su_n;
   logic [3:0]    dec_mt, dec_mu, dec_st, dec_su;
   logic          done_n, err_n;
   logic          preset_ok, is_zero, dec_zero, take_pause;

   // One-second borrow chain: each digit wraps to its maximum and borrows upward.
   always_comb begin
      dec_mt = mt;
      dec_mu = mu;
      dec_st = st;
      dec_su = su - 4'd1;
      if (su == 4'd0) begin
         dec_su = 4'd9;
         dec_st = st - 4'd1;
         if (st == 4'd0) begin
            dec_st = 4'd5;
            dec_mu = mu - 4'd1;
            if (mu == 4'd0) begin
               dec_mu = 4'd9;
               dec_mt = mt - 4'd1;
            end
         end
      end
   end

   assign preset_ok  = (pre_mt <= 4'd9) && (pre_mu <= 4'd9) &&
                       (pre_st <= 4'd5) && (pre_su <= 4'd9);
   assign is_zero    = (mt == 4'd0) && (mu == 4'd0) && (st == 4'd0) && (su == 4'd0);
   assign dec_zero   = (dec_mt == 4'd0) && (dec_mu == 4'd0) &&
                       (dec_st == 4'd0) && (dec_su == 4'd0);
   // A load or start in the same cycle masks pause, even where they are ignored.
   assign take_pause = pause && !load && !start;

   always_comb begin
      state_n = state;
      presc_n = presc;
      mt_n    = mt;
      mu_n    = mu;
      st_n    = st;
      su_n    = su;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (load) begin
               if (preset_ok) begin
                  mt_n    = pre_mt;
                  mu_n    = pre_mu;
                  st_n    = pre_st;
                  su_n    = pre_su;
                  state_n = IDLE;
               end else begin
                  err_n = 1'b1;
               end
            end else if (start && state == IDLE) begin
               if (is_zero) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  state_n = RUN;
                  presc_n = '0;
               end
            end
         end
         RUN: begin
            if (take_pause) begin
               state_n = PAUSE;
            end else if (presc == PRESC_LAST) begin
               presc_n = '0;
               mt_n    = dec_mt;
               mu_n    = dec_mu;
               st_n    = dec_st;
               su_n    = dec_su;
               if (dec_zero) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end else begin
               presc_n = presc + 1'b1;
            end
         end
         PAUSE: begin
            if (take_pause) begin
               state_n = RUN;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state    <= IDLE;
         presc    <= '0;
         mt       <= 4'd0;
         mu       <= 4'd0;
         st       <= 4'd0;
         su       <= 4'd0;
         done     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state    <= state_n;
         presc    <= presc_n;
         mt       <= mt_n;
         mu       <= mu_n;
         st       <= st_n;
         su       <= su_n;
         done     <= done_n;
         load_err <= err_n;
      end
   end

   assign running = (state == RUN);
   assign dig_mt  = mt;
   assign dig_mu  = mu;
   assign dig_st  = st;
   assign dig_su  = su;

endmodule

// File: tb/tb_irrigation_countdown.sv
// Randomised and directed bench for irrigation_countdown; expectations come from
// a seconds-based reference model updated once per clock edge.
module tb_irrigation_countdown;

   localparam int TICK_DIV = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       load = 1'b0, start = 1'b0, pause = 1'b0;
   logic [3:0] pre_mt = '0, pre_mu = '0, pre_st = '0, pre_su = '0;
   logic [3:0] dig_mt, dig_mu, dig_st, dig_su;
   logic       running, done, load_err;
   logic [18:0] obs;

   int checks = 0;
   int failures = 0;

   int m_secs, m_mode, m_tick;
   logic m_done, m_err;

   irrigation_countdown #(.TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .clear(clear), .load(load), .start(start), .pause(pause),
      .pre_mt(pre_mt), .pre_mu(pre_mu), .pre_st(pre_st), .pre_su(pre_su),
      .dig_mt(dig_mt), .dig_mu(dig_mu), .dig_st(dig_st), .dig_su(dig_su),
      .running(running), .done(done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   assign obs = {dig_mt, dig_mu, dig_st, dig_su, running, done, load_err};

   function automatic logic [18:0] exp_vec();
      return {4'(m_secs / 600), 4'((m_secs / 60) % 10), 4'((m_secs % 60) / 10),
              4'(m_secs % 10), (m_mode == M_RUN), m_done, m_err};
   endfunction

   function automatic logic [15:0] mmss(input int mins, input int secs);
      return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
   endfunction

   task automatic model_reset();
      m_secs = 0; m_mode = M_IDLE; m_tick = 0; m_done = 0; m_err = 0;
   endtask

   // Behaviour in terms of total seconds: one clock edge of the controller.
   task automatic model_clock();
      int prev;
      prev = m_mode;
      m_done = 0;
      m_err = 0;
      if (load) begin
         if (prev == M_IDLE || prev == M_DONE) begin
            if (pre_mt <= 9 && pre_mu <= 9 && pre_st <= 5 && pre_su <= 9) begin
               m_secs = (int'(pre_mt) * 10 + int'(pre_mu)) * 60 + int'(pre_st) * 10 + int'(pre_su);
               m_mode = M_IDLE;
            end else begin
               m_err = 1;
            end
         end
      end else if (start) begin
         if (prev == M_IDLE) begin
            if (m_secs == 0) begin
               m_mode = M_DONE; m_done = 1;
            end else begin
               m_mode = M_RUN; m_tick = 0;
            end
         end
      end else if (pause && prev == M_RUN) begin
         m_mode = M_PAUSE;
      end else if (pause && prev == M_PAUSE) begin
         m_mode = M_RUN;
      end
      if (prev == M_RUN && m_mode == M_RUN) begin
         m_tick++;
         if (m_tick == TICK_DIV) begin
            m_tick = 0;
            m_secs--;
            if (m_secs == 0) begin
               m_mode = M_DONE; m_done = 1;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      load = 0; start = 0; pause = 0;
   endtask

   task automatic set_preset(input int mt, input int mu, input int st, input int su);
      pre_mt = 4'(mt); pre_mu = 4'(mu); pre_st = 4'(st); pre_su = 4'(su);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear = 1;
      model_reset();
      #2;
      clear = 0;
   endtask

   task automatic test_reset();
      do_reset();
      step();
      checks++;
      if (obs !== exp_vec() || obs !== 19'd0) begin
         failures++;
         $display("FAIL reset_state got=%h expected=%h", obs, 19'd0);
      end
   endtask

   task automatic test_countdown();
      int pulses;
      pulses = 0;
      do_reset();
      set_preset(0, 0, 0, 3); load = 1; step();
      start = 1; step();
      checks++;
      if (obs !== exp_vec() || running !== 1'b1) begin
         failures++;
         $display("FAIL countdown_start got=%h expected=%h", obs, exp_vec());
      end
      for (int i = 0; i < 14; i++) begin
         step();
         if (done) pulses++;
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL countdown_cycle%0d got=%h expected=%h", i, obs, exp_vec());
         end
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL countdown_done_pulses got=%0d expected=1", pulses);
      end
   endtask

   task automatic test_borrow();
      do_reset();
      set_preset(1, 0, 0, 0); load = 1; step();
      start = 1; step();
      repeat (TICK_DIV) step();
      checks++;
      if (obs !== exp_vec() || obs[18:3] !== mmss(9, 59)) begin
         failures++;
         $display("FAIL borrow_10_00 got=%h expected=%h", obs[18:3], mmss(9, 59));
      end
      do_reset();
      set_preset(0, 1, 0, 0); load = 1; step();
      start = 1; step();
      repeat (TICK_DIV) step();
      checks++;
      if (obs !== exp_vec() || obs[18:3] !== mmss(0, 59)) begin
         failures++;
         $display("FAIL borrow_01_00 got=%h expected=%h", obs[18:3], mmss(0, 59));
      end
   endtask

   task automatic test_invalid_load();
      do_reset();
      set_preset(0, 0, 2, 7); load = 1; step();
      set_preset(0, 0, 6, 0); load = 1; step();
      checks++;
      if (obs !== exp_vec() || load_err !== 1'b1) begin
         failures++;
         $display("FAIL invalid_st got=%h expected=%h", obs, exp_vec());
      end
      set_preset(0, 0, 1, 10); load = 1; step();
      checks++;
      if (obs !== exp_vec() || obs[18:3] !== mmss(0, 27)) begin
         failures++;
         $display("FAIL invalid_su got=%h expected=%h", obs, exp_vec());
      end
      start = 1; step();
      set_preset(0, 0, 6, 0); load = 1; step();
      checks++;
      if (obs !== exp_vec() || load_err !== 1'b0) begin
         failures++;
         $display("FAIL load_in_run got=%h expected=%h", obs, exp_vec());
      end
   endtask

   task automatic test_pause();
      do_reset();
      set_preset(0, 0, 0, 5); load = 1; step();
      start = 1; step();
      repeat (2) step();
      pause = 1; step();
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (obs !== exp_vec() || obs[18:3] !== mmss(0, 5)) begin
            failures++;
            $display("FAIL pause_hold%0d got=%h expected=%h", i, obs, exp_vec());
         end
      end
      pause = 1; step();
      step();
      checks++;
      if (obs !== exp_vec() || obs[18:3] !== mmss(0, 5)) begin
         failures++;
         $display("FAIL pause_resume1 got=%h expected=%h", obs, exp_vec());
      end
      step();
      checks++;
      if (obs !== exp_vec() || obs[18:3] !== mmss(0, 4)) begin
         failures++;
         $display("FAIL pause_resume2 got=%h expected=%h", obs[18:3], mmss(0, 4));
      end
   endtask

   task automatic test_zero_and_priority();
      do_reset();
      set_preset(0, 0, 0, 0); load = 1; step();
      start = 1; step();
      checks++;
      if (obs !== exp_vec() || done !== 1'b1 || running !== 1'b0) begin
         failures++;
         $display("FAIL zero_start got=%h expected=%h", obs, exp_vec());
      end
      set_preset(0, 0, 0, 2); load = 1; step();
      load = 1; start = 1; step();
      repeat (3) begin
         step();
         checks++;
         if (obs !== exp_vec() || running !== 1'b0) begin
            failures++;
            $display("FAIL load_start_priority got=%h expected=%h", obs, exp_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_preset(0, 0, 0, 9); load = 1; step();
      start = 1; step();
      repeat (5) step();
      #2 clear = 1;
      model_reset();
      #1;
      checks++;
      if (obs !== 19'd0 || obs !== exp_vec()) begin
         failures++;
         $display("FAIL async_clear got=%h expected=%h", obs, 19'd0);
      end
      @(negedge clk);
      clear = 0;
      step();
      checks++;
      if (obs !== exp_vec() || done !== 1'b0) begin
         failures++;
         $display("FAIL after_clear got=%h expected=%h", obs, exp_vec());
      end
      start = 1; step();
      checks++;
      if (obs !== exp_vec() || done !== 1'b1) begin
         failures++;
         $display("FAIL clear_then_start got=%h expected=%h", obs, exp_vec());
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 800; i++) begin
         load  = ($urandom % 9 == 0);
         start = ($urandom % 6 == 0);
         pause = ($urandom % 8 == 0);
         set_preset(($urandom % 12 == 0) ? int'($urandom % 16) : 0,
                    int'($urandom % 2), int'($urandom % 7), int'($urandom % 11));
         step();
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL random_cycle%0d got=%h expected=%h", i, obs, exp_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_countdown();
      test_borrow();
      test_invalid_load();
      test_pause();
      test_zero_and_priority();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/irrigation_countdown.md
Name: irrigation_countdown

Overview:
- Down-counting BCD irrigation timer, MM:SS format, range 00:00 to 99:59.
- Counts in the opposite direction to the up-counting seconds/tens digit chain already in the timer path.
- Loads a preset watering duration, decrements once per second, and flags completion so the valve controller can close the valve.
- Digit outputs feed the existing 7-segment display decoders unchanged.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1 s decrement. Minimum 2. Prescaler width = ceil(log2(TICK_DIV)).

Ports:
- clk  in  1  system clock, rising edge
- clear  in  1  asynchronous active-high reset
- load  in  1  single-cycle strobe: capture preset digits
- start  in  1  single-cycle strobe: begin countdown
- pause  in  1  single-cycle strobe: toggle RUN/PAUSE
- pre_mt  in  4  preset minutes tens, BCD 0-9
- pre_mu  in  4  preset minutes units, BCD 0-9
- pre_st  in  4  preset seconds tens, BCD 0-5
- pre_su  in  4  preset seconds units, BCD 0-9
- dig_mt  out  4  current minutes tens
- dig_mu  out  4  current minutes units
- dig_st  out  4  current seconds tens
- dig_su  out  4  current seconds units
- running  out  1  high while in RUN
- done  out  1  one-cycle pulse on reaching 00:00
- load_err  out  1  one-cycle pulse when a preset is rejected

Behaviour:
- Reset (clear high, asynchronous):
  - all digits = 0, state = IDLE, prescaler = 0
  - running = 0, done = 0, load_err = 0
  - reset is honoured mid-count, with no completion pulse.
- States: IDLE, RUN, PAUSE, DONE. Registered outputs, so one cycle of latency from strobe to output.
- Strobe priority in the same cycle: load > start > pause. Lower-priority strobes in that cycle are ignored.
- load:
  - Accepted only in IDLE or DONE.
  - Preset is valid when every digit is <= 9 and pre_st <= 5. A valid preset is copied to the digits and the state goes to IDLE.
  - An invalid preset leaves the digits unchanged and pulses load_err.
  - load in RUN or PAUSE is ignored, with no load_err.
- start:
  - Accepted only in IDLE.
  - If the digits are 00:00: go to DONE and pulse done the next cycle.
  - Otherwise: go to RUN and clear the prescaler.
  - start in RUN, PAUSE or DONE is ignored.
- RUN:
  - The prescaler increments every cycle. When it equals TICK_DIV-1, it wraps to 0 and the value decrements by one second.
  - The first decrement happens exactly TICK_DIV cycles after the start-accept edge.
- Decrement rules:
  - su 0 becomes 9 and borrows from st.
  - st 0 becomes 5 and borrows from mu.
  - mu 0 becomes 9 and borrows from mt.
  - mt only decrements. 00:00 is never decremented.
- Completion: the decrement that produces 00:00 moves the state to DONE. done pulses high for one cycle on that same edge; running falls on that edge.
- pause:
  - In RUN, pause moves to PAUSE and freezes both prescaler and digits.
  - In PAUSE, pause returns to RUN and resumes the prescaler from its held value.
  - pause in IDLE or DONE is ignored.
- DONE:
  - Digits hold 00:00 until a valid load.
  - start is ignored; a new cycle requires load then start.
- running = 1 only in RUN. In PAUSE, running = 0 and the digits remain visible.

Test Plan:
- TICK_DIV=4, clear, then load 00:03, start:
  - running rises one cycle after start
  - digits read 00:02, 00:01, 00:00 at 4-cycle intervals
  - done pulses exactly once, coincident with 00:00
  - running falls on the same edge.
- Borrow chain: load 10:00, start, one tick -> 09:59. Load 01:00, one tick -> 00:59.
- Invalid preset: load with pre_st=6, then with pre_su=10 -> load_err pulses each time and the digits are unchanged. load during RUN -> ignored, no load_err.
- Pause: 00:05 running, pause after 2 cycles of a tick period, hold 20 cycles -> digits frozen. Pause again -> next decrement after 2 more cycles.
- Zero start and priority:
  - start with 00:00 loaded -> DONE and done pulse, no RUN.
  - load and start in the same cycle from IDLE -> only the load takes effect, state stays IDLE.
- Async reset: assert clear mid-RUN, off a clock edge -> digits 0, IDLE immediately, no done pulse. Deassert, then start -> done pulse (00:00 case).
